// File: rtl/mtimer_wb_pkg.sv
// Shared constants for the machine timer register block: register map, reset values,
// bus width, and the Wishbone byte-lane merge helper.
package mtimer_wb_pkg;

  localparam int unsigned WB_DW    = 32;
  localparam int unsigned WB_SEL_W = WB_DW / 8;

  localparam logic [3:0] MTIME_LO    = 4'h0;
  localparam logic [3:0] MTIME_HI    = 4'h4;
  localparam logic [3:0] MTIMECMP_LO = 4'h8;
  localparam logic [3:0] MTIMECMP_HI = 4'hC;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Replace the byte lanes of old_val enabled in sel with the matching lanes of wdat.
  function automatic logic [WB_DW-1:0] wb_merge(input logic [WB_DW-1:0]    old_val,
                                                input logic [WB_DW-1:0]    wdat,
                                                input logic [WB_SEL_W-1:0] sel);
    logic [WB_DW-1:0] merged;
    merged = old_val;
    for (int unsigned b = 0; b < WB_SEL_W; b++) begin
      if (sel[b]) merged[8*b +: 8] = wdat[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Divides clk down to the mtime increment rate: inc_en_c_o is high one cycle in PRESCALE.
module mtimer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk_i,
  input  logic res_i,
  output logic inc_en_c_o
);

  localparam int unsigned CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (res_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign inc_en_c_o = (count_q == LAST);

endmodule

// File: rtl/mtimer_wb.sv
// RISC-V machine timer (mtime/mtimecmp) behind a Wishbone pipelined slave port,
// producing the watchdog tick pulse and the machine timer interrupt.
module mtimer_wb
  import mtimer_wb_pkg::*;
#(
  parameter int unsigned WB_DATA_WIDTH = WB_DW,
  parameter int unsigned WB_ADDR_WIDTH = 4,
  parameter int unsigned CNTR_WIDTH    = 64,
  parameter int unsigned PRESCALE      = 1,
  parameter int unsigned WDG_TICK_BIT  = 2
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic                       i_wb_cyc,
  input  logic                       i_wb_stb,
  output logic                       o_wb_stall,
  input  logic [WB_ADDR_WIDTH-1:0]   i_wb_adr,
  input  logic                       i_wb_we,
  input  logic [WB_DATA_WIDTH-1:0]   i_wb_dat,
  input  logic [WB_DATA_WIDTH/8-1:0] i_wb_sel,
  output logic                       o_wb_ack,
  output logic                       o_wb_err,
  output logic [WB_DATA_WIDTH-1:0]   o_wb_dat,
  output logic                       o_wdg_tick,
  output logic                       o_irq_mtip
);

  localparam int unsigned HW = WB_DATA_WIDTH;

  logic                  inc_en_c;
  logic                  accept_c, adr_ok_c, wr_c, rd_c;
  logic [CNTR_WIDTH-1:0] mtime_q, mtime_d;
  logic [CNTR_WIDTH-1:0] mtimecmp_q, mtimecmp_d;
  logic [HW-1:0]         shadow_hi_q, shadow_hi_d;
  logic [HW-1:0]         dat_q, dat_d;
  logic                  ack_q, err_q, stall_q, tick_q, irq_q;

  mtimer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk_i      (clk),
    .res_i      (res),
    .inc_en_c_o (inc_en_c)
  );

  // Bus decode and next-state of the timer registers; a SW write to mtime replaces the increment.
  always_comb begin
    accept_c    = i_wb_cyc & i_wb_stb & ~stall_q;
    adr_ok_c    = (i_wb_adr[1:0] == 2'b00);
    wr_c        = accept_c & adr_ok_c & i_wb_we & (|i_wb_sel);
    rd_c        = accept_c & adr_ok_c & ~i_wb_we;
    mtime_d     = mtime_q + CNTR_WIDTH'(inc_en_c);
    mtimecmp_d  = mtimecmp_q;
    shadow_hi_d = shadow_hi_q;
    dat_d       = '0;

    if (wr_c) begin
      unique case (i_wb_adr[3:0])
        MTIME_LO:    mtime_d    = {mtime_q[CNTR_WIDTH-1:HW],
                                   wb_merge(mtime_q[HW-1:0], i_wb_dat, i_wb_sel)};
        MTIME_HI:    mtime_d    = {wb_merge(mtime_q[CNTR_WIDTH-1:HW], i_wb_dat, i_wb_sel),
                                   mtime_q[HW-1:0]};
        MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[CNTR_WIDTH-1:HW],
                                   wb_merge(mtimecmp_q[HW-1:0], i_wb_dat, i_wb_sel)};
        MTIMECMP_HI: mtimecmp_d = {wb_merge(mtimecmp_q[CNTR_WIDTH-1:HW], i_wb_dat, i_wb_sel),
                                   mtimecmp_q[HW-1:0]};
        default: ;
      endcase
    end

    // Reading the low half latches the high half so lo-then-hi forms one atomic 64-bit value.
    if (rd_c) begin
      unique case (i_wb_adr[3:0])
        MTIME_LO: begin
          dat_d       = mtime_q[HW-1:0];
          shadow_hi_d = mtime_q[CNTR_WIDTH-1:HW];
        end
        MTIME_HI:    dat_d = shadow_hi_q;
        MTIMECMP_LO: dat_d = mtimecmp_q[HW-1:0];
        MTIMECMP_HI: dat_d = mtimecmp_q[CNTR_WIDTH-1:HW];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      mtime_q     <= '0;
      mtimecmp_q  <= CNTR_WIDTH'(MTIMECMP_RST);
      shadow_hi_q <= '0;
      dat_q       <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      stall_q     <= 1'b0;
      tick_q      <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      shadow_hi_q <= shadow_hi_d;
      dat_q       <= dat_d;
      ack_q       <= accept_c & adr_ok_c;
      err_q       <= accept_c & ~adr_ok_c;
      stall_q     <= accept_c;
      tick_q      <= mtime_d[WDG_TICK_BIT] ^ mtime_q[WDG_TICK_BIT];
      irq_q       <= (mtime_q >= mtimecmp_q);
    end
  end

  assign o_wb_stall = stall_q;
  assign o_wb_ack   = ack_q;
  assign o_wb_err   = err_q;
  assign o_wb_dat   = dat_q;
  assign o_wdg_tick = tick_q;
  assign o_irq_mtip = irq_q;

endmodule

// File: tb/tb_mtimer_wb.sv
// Self-checking bench for mtimer_wb: register-map vector table plus timed sequences for
// mtime counting, watchdog ticks, interrupt edges, atomic wrap reads and reset mid-transfer.
module tb_mtimer_wb;

  logic        clk, res;
  logic        i_wb_cyc, i_wb_stb, i_wb_we;
  logic [3:0]  i_wb_adr, i_wb_sel;
  logic [31:0] i_wb_dat;
  logic        o_wb_stall, o_wb_ack, o_wb_err, o_wdg_tick, o_irq_mtip;
  logic [31:0] o_wb_dat;

  typedef struct {
    logic        we;
    logic [3:0]  adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] dat;
  } resp_t;

  localparam int unsigned NVEC = 17;

  vec_t  vecs[NVEC];
  resp_t sb[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  mtimer_wb #(
    .WB_DATA_WIDTH (32),
    .WB_ADDR_WIDTH (4),
    .CNTR_WIDTH    (64),
    .PRESCALE      (1),
    .WDG_TICK_BIT  (2)
  ) dut (
    .clk        (clk),
    .res        (res),
    .i_wb_cyc   (i_wb_cyc),
    .i_wb_stb   (i_wb_stb),
    .o_wb_stall (o_wb_stall),
    .i_wb_adr   (i_wb_adr),
    .i_wb_we    (i_wb_we),
    .i_wb_dat   (i_wb_dat),
    .i_wb_sel   (i_wb_sel),
    .o_wb_ack   (o_wb_ack),
    .o_wb_err   (o_wb_err),
    .o_wb_dat   (o_wb_dat),
    .o_wdg_tick (o_wdg_tick),
    .o_irq_mtip (o_irq_mtip)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One Wishbone transfer: wait for stall low, drive for one edge, then pop and compare the response.
  task automatic wb_xfer(input string tag, input logic we, input logic [3:0] adr,
                         input logic [31:0] wdat, input logic [3:0] sel,
                         input logic exp_err, input logic [31:0] exp_dat);
    resp_t exp;
    int    waits;
    waits = 0;
    @(negedge clk);
    while (o_wb_stall && waits < 8) begin
      @(negedge clk);
      waits++;
    end
    n_chk++;
    if (o_wb_stall) begin
      n_fail++;
      $display("FAIL %s_stall_free: stall=1, expected 0 before request", tag);
      return;
    end
    sb.push_back('{err: exp_err, dat: exp_dat});
    i_wb_cyc = 1'b1;
    i_wb_stb = 1'b1;
    i_wb_we  = we;
    i_wb_adr = adr;
    i_wb_dat = wdat;
    i_wb_sel = sel;
    @(posedge clk);
    #1;
    i_wb_cyc = 1'b0;
    i_wb_stb = 1'b0;
    i_wb_we  = 1'b0;
    i_wb_adr = 4'h0;
    i_wb_dat = 32'h0;
    i_wb_sel = 4'h0;
    chk({tag, "_stall_busy"}, 64'(o_wb_stall), 64'(1'b1));
    @(negedge clk);
    exp = sb.pop_front();
    n_chk++;
    if ((o_wb_ack !== ~exp.err) || (o_wb_err !== exp.err) || (o_wb_dat !== exp.dat)) begin
      n_fail++;
      $display("FAIL %s: ack=%0b err=%0b dat=0x%08h, expected ack=%0b err=%0b dat=0x%08h",
               tag, o_wb_ack, o_wb_err, o_wb_dat, ~exp.err, exp.err, exp.dat);
    end
  endtask

  task automatic wb_wr(input string tag, input logic [3:0] adr, input logic [31:0] wdat,
                       input logic [3:0] sel);
    wb_xfer(tag, 1'b1, adr, wdat, sel, 1'b0, 32'h0);
  endtask

  task automatic wb_rd(input string tag, input logic [3:0] adr, input logic [31:0] exp_dat);
    wb_xfer(tag, 1'b0, adr, 32'h0, 4'h0, 1'b0, exp_dat);
  endtask

  initial begin
    int   ticks;
    int   dbl;
    logic prev_tick;

    vecs[0]  = '{1'b1, 4'h8, 32'h0000_AB00, 4'b0010, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 4'h8, 32'h0,         4'b0000, 1'b0, 32'hFFFF_ABFF};
    vecs[2]  = '{1'b1, 4'h2, 32'h0,         4'b1111, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 4'h8, 32'h0,         4'b0000, 1'b0, 32'hFFFF_ABFF};
    vecs[4]  = '{1'b0, 4'hC, 32'h0,         4'b0000, 1'b0, 32'hFFFF_FFFF};
    vecs[5]  = '{1'b1, 4'hC, 32'hAAAA_5555, 4'b0011, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 4'hC, 32'h0,         4'b0000, 1'b0, 32'hFFFF_5555};
    vecs[7]  = '{1'b1, 4'h8, 32'h1234_5678, 4'b0000, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 4'h8, 32'h0,         4'b0000, 1'b0, 32'hFFFF_ABFF};
    vecs[9]  = '{1'b0, 4'h3, 32'h0,         4'b0000, 1'b1, 32'h0};
    vecs[10] = '{1'b1, 4'hD, 32'h0,         4'b1111, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 4'hC, 32'h0,         4'b0000, 1'b0, 32'hFFFF_5555};
    vecs[12] = '{1'b1, 4'hC, 32'h0011_0000, 4'b1100, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 4'hC, 32'h0,         4'b0000, 1'b0, 32'h0011_5555};
    vecs[14] = '{1'b1, 4'hC, 32'hFFFF_FFFF, 4'b1111, 1'b0, 32'h0};
    vecs[15] = '{1'b1, 4'h8, 32'hFFFF_FFFF, 4'b1111, 1'b0, 32'h0};
    vecs[16] = '{1'b0, 4'h8, 32'h0,         4'b0000, 1'b0, 32'hFFFF_FFFF};

    res      = 1'b1;
    i_wb_cyc = 1'b0;
    i_wb_stb = 1'b0;
    i_wb_we  = 1'b0;
    i_wb_adr = 4'h0;
    i_wb_dat = 32'h0;
    i_wb_sel = 4'h0;

    // Reset state, then 8 free-running increments
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack",   64'(o_wb_ack),   64'(1'b0));
    chk("rst_err",   64'(o_wb_err),   64'(1'b0));
    chk("rst_stall", 64'(o_wb_stall), 64'(1'b0));
    chk("rst_dat",   64'(o_wb_dat),   64'(32'h0));
    chk("rst_tick",  64'(o_wdg_tick), 64'(1'b0));
    chk("rst_irq",   64'(o_irq_mtip), 64'(1'b0));
    res = 1'b0;
    repeat (8) @(posedge clk);
    wb_rd("t1_mtime_lo", 4'h0, 32'd8);
    chk("t1_irq", 64'(o_irq_mtip), 64'(1'b0));

    // Register map, byte lanes and misaligned errors
    for (int i = 0; i < int'(NVEC); i++) begin
      wb_xfer($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].wdat, vecs[i].sel,
              vecs[i].exp_err, vecs[i].exp_dat);
    end

    // 32 increments with no SW writes -> 8 single-cycle ticks
    ticks     = 0;
    dbl       = 0;
    prev_tick = 1'b0;
    repeat (32) begin
      @(negedge clk);
      if (o_wdg_tick) ticks++;
      if (o_wdg_tick && prev_tick) dbl++;
      prev_tick = o_wdg_tick;
    end
    chk("t2_tick_count", 64'(ticks), 64'd8);
    chk("t2_tick_width", 64'(dbl),   64'd0);

    // Interrupt rises one cycle after mtime reaches mtimecmp, falls when mtimecmp is raised
    wb_wr("t3_mtime_lo0", 4'h0, 32'h0, 4'hF);
    wb_wr("t3_cmp_hi",    4'hC, 32'h0, 4'hF);
    wb_wr("t3_cmp_lo",    4'h8, 32'h20, 4'hF);
    chk("t3_irq_low_before", 64'(o_irq_mtip), 64'(1'b0));
    wb_wr("t3_mtime_lo",  4'h0, 32'h10, 4'hF);
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk("t3_irq_at_match", 64'(o_irq_mtip), 64'(1'b0));
    @(negedge clk);
    chk("t3_irq_rise", 64'(o_irq_mtip), 64'(1'b1));
    wb_wr("t3_cmp_raise", 4'h8, 32'hFFFF_FFFF, 4'hF);
    chk("t3_irq_lag", 64'(o_irq_mtip), 64'(1'b1));
    @(negedge clk);
    chk("t3_irq_fall", 64'(o_irq_mtip), 64'(1'b0));

    // Atomic lo/hi reads across the 32-bit carry
    wb_wr("t4_mtime_hi", 4'h4, 32'h0, 4'hF);
    wb_wr("t4_mtime_lo", 4'h0, 32'hFFFF_FFFE, 4'hF);
    wb_rd("t4_lo_pre",  4'h0, 32'hFFFF_FFFF);
    wb_rd("t4_hi_pre",  4'h4, 32'h0);
    wb_rd("t4_lo_post", 4'h0, 32'h0000_0003);
    wb_rd("t4_hi_post", 4'h4, 32'h0000_0001);
    chk("t4_irq_64bit", 64'(o_irq_mtip), 64'(1'b1));

    // SW write collides with an increment (every cycle increments here)
    wb_wr("t6_cmp_hi",   4'hC, 32'hFFFF_FFFF, 4'hF);
    wb_wr("t6_mtime_lo", 4'h0, 32'h0000_1000, 4'hF);
    wb_rd("t6_lo",       4'h0, 32'h0000_1001);
    wb_rd("t6_hi",       4'h4, 32'h0000_0001);
    chk("t6_irq_clear", 64'(o_irq_mtip), 64'(1'b0));

    // Reset asserted on the accept edge drops the response
    wb_wr("t7_cmp_lo", 4'h8, 32'h0000_0005, 4'hF);
    @(negedge clk);
    res      = 1'b1;
    i_wb_cyc = 1'b1;
    i_wb_stb = 1'b1;
    i_wb_we  = 1'b0;
    i_wb_adr = 4'h8;
    @(posedge clk);
    #1;
    i_wb_cyc = 1'b0;
    i_wb_stb = 1'b0;
    i_wb_adr = 4'h0;
    @(negedge clk);
    chk("t7_rst_ack",   64'(o_wb_ack),   64'(1'b0));
    chk("t7_rst_err",   64'(o_wb_err),   64'(1'b0));
    chk("t7_rst_stall", 64'(o_wb_stall), 64'(1'b0));
    @(negedge clk);
    chk("t7_rst_ack2",  64'(o_wb_ack),   64'(1'b0));
    res = 1'b0;
    wb_rd("t7_mtime_lo", 4'h0, 32'h1);
    wb_rd("t7_cmp_lo",   4'h8, 32'hFFFF_FFFF);
    wb_rd("t7_cmp_hi",   4'hC, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
